// File: rtl/nibble_serial_adder.sv
// Nibble-serial 16-bit adder controller.
// Sequences a 16-bit add through an external combinational 4-bit full-adder
// stage, one nibble per clock, least-significant nibble first, and registers
// the 16-bit sum, the final carry and the two's-complement overflow flag.
//
// Handshake: Start_in is a request sampled only in IDLE; the edge that sees
// it high accepts it and latches the operands (edge 0). Nibbles are captured
// on edges 1-4, then Done_out pulses for exactly one cycle with the result
// valid on Sum_out/Cout_out/Ovf_out. Start_in seen in RUN or DONE is dropped,
// not queued. Busy_out marks RUN and never overlaps Done_out.
module nibble_serial_adder (
    input  logic        Clk_in,
    input  logic        Rst_in,
    input  logic        Start_in,
    input  logic [15:0] OpA_in,
    input  logic [15:0] OpB_in,
    input  logic        Cin_in,
    output logic [3:0]  Add_A_out,
    output logic [3:0]  Add_B_out,
    output logic        Add_C_out,
    input  logic [3:0]  Add_S_in,
    input  logic        Add_Cout_in,
    output logic        Busy_out,
    output logic        Done_out,
    output logic [15:0] Sum_out,
    output logic        Cout_out,
    output logic        Ovf_out,
    output logic [1:0]  State_dbg_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [15:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;

    // State register with asynchronous reset back to IDLE.
    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE waits for a request, RUN walks four nibbles, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (Start_in) state_d = S_RUN;
            S_RUN:  if (idx_q == 2'd3) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: status flags from state, adder drive only while running.
    always_comb begin
        Busy_out  = (state_q == S_RUN);
        Done_out  = (state_q == S_DONE);
        Add_A_out = 4'd0;
        Add_B_out = 4'd0;
        Add_C_out = 1'b0;
        if (state_q == S_RUN) begin
            Add_A_out = opa_q[{idx_q, 2'b00} +: 4];
            Add_B_out = opb_q[{idx_q, 2'b00} +: 4];
            Add_C_out = carry_q;
        end
    end

    // Datapath next values: latch on accept, capture one nibble per RUN cycle.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == S_IDLE && Start_in) begin
            opa_d   = OpA_in;
            opb_d   = OpB_in;
            carry_d = Cin_in;
            idx_d   = 2'd0;
        end else if (state_q == S_RUN) begin
            sum_d[{idx_q, 2'b00} +: 4] = Add_S_in;
            carry_d = Add_Cout_in;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                // Overflow: like-signed operands producing a differently-signed sum.
                cout_d = Add_Cout_in;
                ovf_d  = (opa_q[15] == opb_q[15]) && (Add_S_in[3] != opa_q[15]);
            end
        end
    end

    // Datapath registers; reset clears operands, progress and the result.
    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            opa_q   <= 16'd0;
            opb_q   <= 16'd0;
            sum_q   <= 16'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Sum_out       = sum_q;
    assign Cout_out      = cout_q;
    assign Ovf_out       = ovf_q;
    assign State_dbg_out = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: external 4-bit adder stage model,
// table of directed add vectors with hand-computed results, and hand-written
// sequences for ignored starts and reset during an add.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        cin;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_c;
  logic [3:0]  add_s;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  // External 4-bit full-adder stage.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_c};

  // Count cycles with Done high, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  nibble_serial_adder dut (
    .Clk_in        (clk),
    .Rst_in        (rst),
    .Start_in      (start),
    .OpA_in        (opa),
    .OpB_in        (opb),
    .Cin_in        (cin),
    .Add_A_out     (add_a),
    .Add_B_out     (add_b),
    .Add_C_out     (add_c),
    .Add_S_in      (add_s),
    .Add_Cout_in   (add_cout),
    .Busy_out      (busy),
    .Done_out      (done),
    .Sum_out       (sum),
    .Cout_out      (cout),
    .Ovf_out       (ovf),
    .State_dbg_out (state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_drive_zero(input string tag);
    chk({tag, "_add_a0"}, {28'd0, add_a}, 32'd0);
    chk({tag, "_add_b0"}, {28'd0, add_b}, 32'd0);
    chk({tag, "_add_c0"}, {31'd0, add_c}, 32'd0);
  endtask

  // mode 0: plain add; mode 1: extra Start during RUN; mode 2: Start held in DONE.
  task automatic run_add(input vec_t v, input int mode);
    logic       c;
    logic [4:0] nib;
    int         dc0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk_drive_zero("idle");
    start = 1'b1; opa = v.a; opb = v.b; cin = v.cin;
    dc0 = done_cnt;
    @(posedge clk);  // edge 0: accept
    #1;
    start = 1'b0;
    opa = 16'($urandom); opb = 16'($urandom); cin = 1'($urandom_range(0, 1));
    c = v.cin;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_done", {31'd0, done}, 32'd0);
      chk("run_add_a", {28'd0, add_a}, {28'd0, v.a[4*n +: 4]});
      chk("run_add_b", {28'd0, add_b}, {28'd0, v.b[4*n +: 4]});
      chk("run_add_c", {31'd0, add_c}, {31'd0, c});
      nib = {1'b0, v.a[4*n +: 4]} + {1'b0, v.b[4*n +: 4]} + {4'd0, c};
      c = nib[4];
      if (mode == 1) begin
        if (n == 1) begin
          start = 1'b1; opa = 16'h0002;
        end else if (n == 2) begin
          start = 1'b0;
        end
      end
      @(posedge clk);
    end
    @(negedge clk);  // between edges 4 and 5
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("sum", {16'd0, sum}, {16'd0, v.sum});
    chk("cout", {31'd0, cout}, {31'd0, v.cout});
    chk("ovf", {31'd0, ovf}, {31'd0, v.ovf});
    chk_drive_zero("done");
    if (mode == 2) start = 1'b1;
    @(negedge clk);  // after edge 5
    start = 1'b0;
    chk("after_done", {31'd0, done}, 32'd0);
    chk("after_busy", {31'd0, busy}, 32'd0);
    chk("sum_hold", {16'd0, sum}, {16'd0, v.sum});
    chk("cout_hold", {31'd0, cout}, {31'd0, v.cout});
    chk("done_count", done_cnt - dc0, 32'd1);
  endtask

  initial begin
    vec_t v;
    int   dc0;

    vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0000, cin: 1'b1, sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 16'hABCD, b: 16'h1111, cin: 1'b1, sum: 16'hBCDF, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, sum: 16'h0000, cout: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b1};

    // Clock/reset
    rst = 1'b1; start = 1'b0; opa = 16'hA5A5; opb = 16'h5A5A; cin = 1'b1;
    #1;
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk_drive_zero("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle with no request stays idle
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_start", {31'd0, busy}, 32'd0);
    end

    // Table of directed vectors
    for (int i = 0; i < 7; i++) run_add(vecs[i], 0);

    // Second Start during RUN is ignored
    v = '{a: 16'h0004, b: 16'h0003, cin: 1'b0, sum: 16'h0007, cout: 1'b0, ovf: 1'b0};
    run_add(v, 1);
    @(negedge clk);
    chk("no_queued_start", {31'd0, busy}, 32'd0);

    // Start held during DONE is ignored
    v = '{a: 16'h0F0F, b: 16'h00F1, cin: 1'b0, sum: 16'h1000, cout: 1'b0, ovf: 1'b0};
    run_add(v, 2);
    @(negedge clk);
    chk("done_start_ignored", {31'd0, busy}, 32'd0);

    // Reset in the middle of an add (previous result has cout=0, so use a carry-out vector first)
    run_add(vecs[6], 0);
    @(negedge clk);
    start = 1'b1; opa = 16'h1234; opb = 16'h1111; cin = 1'b0;
    @(posedge clk);  // edge 0
    #1 start = 1'b0;
    @(posedge clk);  // edge 1
    @(posedge clk);  // edge 2
    #1;
    chk("partial_sum", {16'd0, sum}, 32'h0045);
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk_drive_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_done_after_rst", done_cnt - dc0, 32'd0);
    chk("idle_after_rst", {31'd0, busy}, 32'd0);

    // Fresh add after reset
    v = '{a: 16'h0002, b: 16'h0003, cin: 1'b1, sum: 16'h0006, cout: 1'b0, ovf: 1'b0};
    run_add(v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Clk_in  input  1  single clock; all state updates on the rising edge.
REQ-002 Rst_in  input  1  asynchronous, active-high reset.
REQ-003 Start_in  input  1  request to begin a 16-bit add; sampled only in IDLE.
REQ-004 OpA_in  input  16  operand A; latched on an accepted Start_in.
REQ-005 OpB_in  input  16  operand B; latched on an accepted Start_in.
REQ-006 Cin_in  input  1  initial carry; latched on an accepted Start_in.
REQ-007 Add_A_out  output  4  current A nibble, driven to the external 4-bit full-adder stage.
REQ-008 Add_B_out  output  4  current B nibble, driven to the 4-bit adder stage.
REQ-009 Add_C_out  output  1  current carry, driven to the 4-bit adder stage.
REQ-010 Add_S_in  input  4  sum nibble returned by the adder stage (combinational path, same cycle).
REQ-011 Add_Cout_in  input  1  carry returned by the adder stage (same cycle).
REQ-012 Busy_out  output  1  high while the add is in progress (state RUN).
REQ-013 Done_out  output  1  single-cycle pulse: result valid.
REQ-014 Sum_out  output  16  registered 16-bit result.
REQ-015 Cout_out  output  1  registered final carry.
REQ-016 Ovf_out  output  1  registered two's-complement overflow flag.

Function
REQ-017 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-018 IDLE: when Start_in=1 on an edge, the block latches OpA_in, OpB_in and Cin_in, sets the nibble index to 0, sets the carry register to Cin_in, and enters RUN; when Start_in=0 it stays in IDLE.
REQ-019 RUN adder drive: Add_A_out=OpA[4*idx+3:4*idx], Add_B_out=OpB[4*idx+3:4*idx], Add_C_out=carry register; these outputs are combinational from the registers.
REQ-020 RUN, each edge: Sum_out[4*idx+3:4*idx] <= Add_S_in, carry <= Add_Cout_in, idx <= idx+1.
REQ-021 RUN, edge at idx=3: in addition to REQ-020, Cout_out <= Add_Cout_in and Ovf_out <= (OpA[15]==OpB[15]) && (Add_S_in[3]!=OpA[15]); the FSM then goes to DONE.
REQ-022 Latency: the edge that accepts Start_in is edge 0; nibbles are captured on edges 1-4; Done_out is high for exactly the cycle between edges 4 and 5.
REQ-023 DONE: Done_out=1 for one cycle, then unconditional return to IDLE; Start_in is ignored while in DONE.
REQ-024 Busy_out=1 only in RUN; Busy_out and Done_out are never high together.
REQ-025 Start_in asserted in RUN or DONE is ignored; latched operands and progress are unaffected, and the request is not queued.
REQ-026 Input changes on OpA_in, OpB_in or Cin_in after acceptance have no effect on the add in progress.
REQ-027 In IDLE and DONE, Add_A_out, Add_B_out and Add_C_out are driven to 0.
REQ-028 Sum_out, Cout_out and Ovf_out hold their last result from DONE until the next accepted Start_in.
REQ-029 Sum_out partial nibbles may change during RUN; consumers qualify the result with Done_out.
REQ-030 Back-to-back operation: the earliest next accept is the edge that leaves DONE+1, i.e. 6 edges between successive accepts.
REQ-031 Arithmetic is unsigned 16-bit modulo 2^16 plus carry; the result satisfies {Cout_out, Sum_out} = OpA + OpB + Cin.

Reset
REQ-032 Rst_in=1 asynchronously forces: state=IDLE, idx=0, carry=0, latched operands=0, Sum_out=0, Cout_out=0, Ovf_out=0, Busy_out=0, Done_out=0, adder drive outputs=0.
REQ-033 Reset asserted mid-RUN aborts the add; no Done_out pulse follows, and the partial result is cleared.
REQ-034 After Rst_in is released, the first edge may accept Start_in.

Verification
REQ-035 Start with A=0x1234, B=0x4321, Cin=0 -> Done 4 edges after accept; Sum=0x5555, Cout=0, Ovf=0.
REQ-036 A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0; carry propagates through all nibbles.
REQ-037 A=0x7FFF, B=0x0000, Cin=1 -> Sum=0x8000, Cout=0, Ovf=1.
REQ-038 Accept A=0x0004, B=0x0003, then pulse Start with A=0x0002 on edge 2 -> the second Start is ignored; result=0x0007, exactly one Done pulse.
REQ-039 Rst_in pulsed after edge 2 of an add -> all outputs 0 immediately, no Done pulse; a fresh add of 0x0002+0x0003+1 then yields 0x0006.
REQ-040 Bench models the 4-bit adder stage and checks Add_A_out/Add_B_out/Add_C_out nibble order 0..3 on every RUN cycle, and checks that all three are 0 in IDLE.
